// File: rtl/digest_streamer_if.sv
// Output stream of the digest streamer: one BUS_WIDTH word per accepted beat.
// A word moves on every rising clk edge where dout_valid && dout_ready; while dout_valid is
// high and dout_ready low, dout/dout_keep/dout_last hold steady and dout_valid stays up.
interface digest_streamer_if #(
    parameter int BUS_WIDTH = 64
);
    logic [BUS_WIDTH-1:0]   dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   dout_last;
    logic [BUS_WIDTH/8-1:0] dout_keep;

    modport master (
        output dout, dout_valid, dout_last, dout_keep,
        input  dout_ready
    );

    modport slave (
        input  dout, dout_valid, dout_last, dout_keep,
        output dout_ready
    );
endinterface

// File: rtl/digest_streamer.sv
// Captures the hash core digest on a digest_valid rise and replays it as a
// least-significant-word-first stream, trimmed to the requested byte length.
module digest_streamer #(
    parameter int BUS_WIDTH    = 64,
    parameter int DIGEST_WIDTH = 512,
    parameter int LEN_WIDTH    = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    digest_valid,
    input  logic [DIGEST_WIDTH-1:0] digest,
    input  logic [LEN_WIDTH-1:0]    digest_bytes,
    input  logic                    abort,
    output logic                    digest_ack,
    digest_streamer_if.master       stream,
    output logic                    busy,
    output logic                    overrun,
    output logic                    state_dbg
);
    localparam int NBYTES = DIGEST_WIDTH / 8;
    localparam int BB     = BUS_WIDTH / 8;
    localparam int NW     = DIGEST_WIDTH / BUS_WIDTH;
    localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int REM_W  = (BB > 1) ? $clog2(BB) : 1;
    localparam int LEN_P1 = LEN_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(NBYTES);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t state;
    state_t state_nxt;

    logic                    digest_valid_q;
    logic                    rise;
    logic                    capture;
    logic                    xfer;
    logic                    is_last;
    logic [DIGEST_WIDTH-1:0] digest_q;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        last_idx_q;
    logic [IDX_W-1:0]        last_idx_calc;
    logic [REM_W-1:0]        rem_q;
    logic [REM_W-1:0]        rem_calc;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic [LEN_WIDTH:0]      len_round;
    logic [BB-1:0]           keep_c;
    logic [BUS_WIDTH-1:0]    byte_mask;

    assign rise      = digest_valid & ~digest_valid_q;
    assign capture   = (state == IDLE) & rise & ~abort;
    assign xfer      = (state == SEND) & stream.dout_ready;
    assign is_last   = (idx == last_idx_q);
    assign state_dbg = state;

    // Zero and oversize requests both mean "whole digest".
    always_comb begin
        len_eff = digest_bytes;
        if (digest_bytes == '0 || digest_bytes > FULL_LEN) begin
            len_eff = FULL_LEN;
        end
        len_round     = {1'b0, len_eff} + LEN_P1'(BB - 1);
        last_idx_calc = IDX_W'(len_round / LEN_P1'(BB) - LEN_P1'(1));
        rem_calc      = REM_W'(len_eff % LEN_WIDTH'(BB));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture) state_nxt = SEND;
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer && is_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
            last_idx_q     <= '0;
            rem_q          <= '0;
            idx            <= '0;
            overrun        <= 1'b0;
        end else begin
            digest_valid_q <= digest_valid;
            // A rise while SEND covers the final-transfer cycle too; that digest is lost.
            if (rise && state == SEND) begin
                overrun <= 1'b1;
            end
            if (capture) begin
                digest_q   <= digest;
                last_idx_q <= last_idx_calc;
                rem_q      <= rem_calc;
                idx        <= '0;
            end else if (state == SEND) begin
                if (abort || (xfer && is_last)) begin
                    idx <= '0;
                end else if (xfer) begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        keep_c = '1;
        if (is_last && rem_q != '0) begin
            for (int b = 0; b < BB; b++) begin
                keep_c[b] = (b < int'(rem_q));
            end
        end
        for (int b = 0; b < BB; b++) begin
            byte_mask[b*8 +: 8] = {8{keep_c[b]}};
        end

        digest_ack        = capture & ~reset;
        stream.dout       = '0;
        stream.dout_valid = 1'b0;
        stream.dout_last  = 1'b0;
        stream.dout_keep  = '0;
        busy              = 1'b0;
        if (state == SEND) begin
            stream.dout       = digest_q[idx*BUS_WIDTH +: BUS_WIDTH] & byte_mask;
            stream.dout_valid = 1'b1;
            stream.dout_last  = is_last;
            stream.dout_keep  = keep_c;
            busy              = 1'b1;
        end
    end
endmodule

// File: tb/tb_digest_streamer.sv
// Directed bench for digest_streamer: timing of capture/stream, trimming, backpressure,
// overrun, reset and abort, with a scoreboard of expected {last, keep, data} beats.
module tb_digest_streamer;
    localparam int BW = 64;
    localparam int DW = 512;
    localparam int LW = 7;
    localparam int KW = BW / 8;
    localparam int W  = BW + KW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          digest_valid;
    logic [DW-1:0] digest;
    logic [LW-1:0] digest_bytes;
    logic          abort;
    logic          digest_ack;
    logic          busy;
    logic          overrun;
    logic          state_dbg;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    int xfer_cnt = 0;
    logic [W-1:0] exp_q[$];

    digest_streamer_if #(.BUS_WIDTH(BW)) bus ();

    digest_streamer #(
        .BUS_WIDTH(BW),
        .DIGEST_WIDTH(DW),
        .LEN_WIDTH(LW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .digest_valid(digest_valid),
        .digest(digest),
        .digest_bytes(digest_bytes),
        .abort(abort),
        .digest_ack(digest_ack),
        .stream(bus),
        .busy(busy),
        .overrun(overrun),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        digest_valid = 1'b0;
        step();
        step();
    endtask

    task automatic start_digest(input logic [DW-1:0] d, input logic [LW-1:0] len);
        digest       = d;
        digest_bytes = len;
        digest_valid = 1'b1;
    endtask

    task automatic push_exp(input logic last, input logic [KW-1:0] keep, input logic [BW-1:0] data);
        exp_q.push_back({last, keep, data});
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 128'(exp_q.size()), 128'd0);
    endtask

    function automatic logic [DW-1:0] words_from(input logic [BW-1:0] base);
        logic [DW-1:0] d;
        for (int w = 0; w < DW / BW; w++) begin
            d[w*BW +: BW] = base | BW'(w + 1);
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] byte_ramp();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 8; i++) begin
            d[i*8 +: 8] = 8'(i + 1);
        end
        return d;
    endfunction

    // scoreboard: every presented beat must match the head of exp_q, popped on acceptance
    always @(negedge clk) begin
        if (!reset && !abort) begin
            if (digest_ack) ack_cnt++;
            if (bus.dout_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 128'(bus.dout_valid), 128'd0);
                end else begin
                    check_eq("beat", 128'({bus.dout_last, bus.dout_keep, bus.dout}), 128'(exp_q[0]));
                    if (bus.dout_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        int a0;
        int x0;
        int c;
        logic [3:0] pat;

        reset          = 1'b1;
        digest_valid   = 1'b0;
        digest         = '0;
        digest_bytes   = '0;
        abort          = 1'b0;
        bus.dout_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_valid", 128'(bus.dout_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_overrun", 128'(overrun), 128'd0);
        check_eq("rst_dout", 128'(bus.dout), 128'd0);
        check_eq("rst_keep", 128'(bus.dout_keep), 128'd0);
        check_eq("rst_state", 128'(state_dbg), 128'd0);
        step();
        reset = 1'b0;
        step();

        // 64-byte digest, words 1..8, full throughput
        for (int k = 1; k <= 8; k++) push_exp(k == 8, 8'hFF, 64'(k));
        start_digest(words_from(64'h0), 7'd64);
        @(negedge clk);
        check_eq("t1_ack", 128'(digest_ack), 128'd1);
        check_eq("t1_busy_pre", 128'(busy), 128'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            check_eq("t1_valid", 128'(bus.dout_valid), 128'd1);
            check_eq("t1_word", 128'(bus.dout), 128'(k));
            check_eq("t1_last", 128'(bus.dout_last), 128'(k == 8));
        end
        step();
        @(negedge clk);
        check_eq("t1_busy_end", 128'(busy), 128'd0);
        check_eq("t1_valid_end", 128'(bus.dout_valid), 128'd0);
        idle_gap();

        // 20-byte digest: three words, last one trimmed to four bytes
        push_exp(1'b0, 8'hFF, 64'h0807060504030201);
        push_exp(1'b0, 8'hFF, 64'h100F0E0D0C0B0A09);
        push_exp(1'b1, 8'h0F, 64'h0000000014131211);
        start_digest(byte_ramp(), 7'd20);
        step();
        digest_valid = 1'b0;
        wait_drain(10, "t2_drain");
        idle_gap();

        // 32-byte digest under ready pattern 1,0,0,1
        pat = 4'b1001;
        a0  = xfer_cnt;
        for (int k = 1; k <= 4; k++) push_exp(k == 4, 8'hFF, 64'hB000_0000_0000_0000 | 64'(k));
        start_digest(words_from(64'hB000_0000_0000_0000), 7'd32);
        c = 0;
        bus.dout_ready = pat[0];
        while (exp_q.size() != 0 && c < 40) begin
            step();
            if (c == 0) digest_valid = 1'b0;
            c++;
            bus.dout_ready = pat[c % 4];
        end
        check_eq("t3_drain", 128'(exp_q.size()), 128'd0);
        check_eq("t3_xfers", 128'(xfer_cnt - a0), 128'd4);
        bus.dout_ready = 1'b1;
        idle_gap();

        // digest_valid held for 30 cycles: exactly one capture
        a0 = ack_cnt;
        x0 = xfer_cnt;
        for (int k = 1; k <= 8; k++) push_exp(k == 8, 8'hFF, 64'hC000_0000_0000_0000 | 64'(k));
        start_digest(words_from(64'hC000_0000_0000_0000), 7'd64);
        repeat (30) step();
        digest_valid = 1'b0;
        wait_drain(5, "t4_drain");
        check_eq("t4_acks", 128'(ack_cnt - a0), 128'd1);
        check_eq("t4_xfers", 128'(xfer_cnt - x0), 128'd8);
        check_eq("t4_overrun", 128'(overrun), 128'd0);
        idle_gap();

        // second rise mid-burst: overrun, first digest intact, second dropped
        a0 = ack_cnt;
        x0 = xfer_cnt;
        for (int k = 1; k <= 8; k++) push_exp(k == 8, 8'hFF, 64'h5500_0000_0000_0000 | 64'(k));
        start_digest(words_from(64'h5500_0000_0000_0000), 7'd64);
        step();
        digest_valid = 1'b0;
        step();
        step();
        start_digest(words_from(64'hDEAD_0000_0000_0000), 7'd64);
        wait_drain(20, "t5_drain");
        check_eq("t5_overrun", 128'(overrun), 128'd1);
        check_eq("t5_acks", 128'(ack_cnt - a0), 128'd1);
        check_eq("t5_xfers", 128'(xfer_cnt - x0), 128'd8);
        repeat (3) step();
        idle_gap();
        @(negedge clk);
        check_eq("t5_sticky", 128'(overrun), 128'd1);
        step();

        // reset at word 4
        for (int k = 1; k <= 8; k++) push_exp(k == 8, 8'hFF, 64'h6600_0000_0000_0000 | 64'(k));
        start_digest(words_from(64'h6600_0000_0000_0000), 7'd64);
        step();
        digest_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        exp_q.delete();
        step();
        @(negedge clk);
        check_eq("t6_rst_valid", 128'(bus.dout_valid), 128'd0);
        check_eq("t6_rst_busy", 128'(busy), 128'd0);
        check_eq("t6_rst_overrun", 128'(overrun), 128'd0);
        check_eq("t6_rst_dout", 128'(bus.dout), 128'd0);
        reset = 1'b0;
        step();

        // abort at word 4
        for (int k = 1; k <= 8; k++) push_exp(k == 8, 8'hFF, 64'h7700_0000_0000_0000 | 64'(k));
        start_digest(words_from(64'h7700_0000_0000_0000), 7'd64);
        step();
        digest_valid = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        exp_q.delete();
        step();
        abort = 1'b0;
        @(negedge clk);
        check_eq("t7_abort_valid", 128'(bus.dout_valid), 128'd0);
        check_eq("t7_abort_busy", 128'(busy), 128'd0);
        check_eq("t7_abort_state", 128'(state_dbg), 128'd0);
        step();

        // fresh capture after abort; length 0 means full digest
        for (int k = 1; k <= 8; k++) push_exp(k == 8, 8'hFF, 64'h8800_0000_0000_0000 | 64'(k));
        start_digest(words_from(64'h8800_0000_0000_0000), 7'd0);
        @(negedge clk);
        check_eq("t8_ack", 128'(digest_ack), 128'd1);
        step();
        digest_valid = 1'b0;
        @(negedge clk);
        check_eq("t8_first_word", 128'(bus.dout), 128'h8800_0000_0000_0001);
        wait_drain(12, "t8_drain");
        idle_gap();

        // abort together with rise: no capture
        start_digest(words_from(64'h9900_0000_0000_0000), 7'd64);
        abort = 1'b1;
        @(negedge clk);
        check_eq("t9_ack", 128'(digest_ack), 128'd0);
        step();
        abort = 1'b0;
        @(negedge clk);
        check_eq("t9_valid", 128'(bus.dout_valid), 128'd0);
        check_eq("t9_busy", 128'(busy), 128'd0);
        idle_gap();

        // oversize length saturates to 64 bytes
        for (int k = 1; k <= 8; k++) push_exp(k == 8, 8'hFF, 64'hAA00_0000_0000_0000 | 64'(k));
        start_digest(words_from(64'hAA00_0000_0000_0000), 7'd100);
        step();
        digest_valid = 1'b0;
        wait_drain(12, "t10_drain");
        idle_gap();

        // single-word digest of 5 bytes
        push_exp(1'b1, 8'h1F, 64'h0000000504030201);
        start_digest(byte_ramp(), 7'd5);
        step();
        digest_valid = 1'b0;
        @(negedge clk);
        check_eq("t11_last", 128'(bus.dout_last), 128'd1);
        check_eq("t11_keep", 128'(bus.dout_keep), 128'h1F);
        wait_drain(4, "t11_drain");
        step();
        @(negedge clk);
        check_eq("t11_busy_end", 128'(busy), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/digest_streamer.md
Name: digest_streamer

Overview:
Output side of the BLAKE2 hashing path. It captures the wide digest from the hash core when `digest_valid` rises, then serializes it onto a BUS_WIDTH-wide valid/ready stream, least-significant word first. The outgoing word count follows the requested digest length, and the final word carries a byte-keep mask. It mirrors the input controller, which packs bus words into 1024-bit blocks; this block unpacks the digest back into bus words.

Parameters:
- BUS_WIDTH, 64: output word width in bits; must be a multiple of 8 and divide DIGEST_WIDTH.
- DIGEST_WIDTH, 512: width of the core digest bus in bits.
- LEN_WIDTH, 7: width of the `digest_bytes` field; must hold DIGEST_WIDTH/8.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `digest_valid`, in, 1: level from the core; high while `digest` holds a valid result.
- `digest`, in, DIGEST_WIDTH: hash result; byte 0 is in bits [7:0].
- `digest_bytes`, in, LEN_WIDTH: requested output length, 1..DIGEST_WIDTH/8. Value 0 is treated as DIGEST_WIDTH/8. Sampled at capture.
- `abort`, in, 1: drops any digest in progress.
- `digest_ack`, out, 1: one-cycle pulse in the capture cycle.
- `dout`, out, BUS_WIDTH: output word.
- `dout_valid`, out, 1: `dout` is valid.
- `dout_ready`, in, 1: downstream accepts the word.
- `dout_last`, out, 1: marks the final word of the digest.
- `dout_keep`, out, BUS_WIDTH/8: byte enables for `dout`.
- `busy`, out, 1: high from capture until the last word is accepted.
- `overrun`, out, 1: sticky error; a new digest arrived while the block was busy.

Behaviour:
Reset:
- All outputs are 0. Internal digest register, word counter and `digest_valid_q` are cleared. State goes to IDLE.
- Reset mid-stream discards the held digest with no further `dout_valid`.

Edge detect:
- `rise = digest_valid & ~digest_valid_q`.
- Only a rise triggers capture. A level held high never re-triggers.

State machine, two states:
- IDLE, on `rise` (with `abort` low):
  - Latch `digest` and `digest_bytes`.
  - Compute `nwords = ceil(len/8)` and `rem = len mod 8`.
  - Pulse `digest_ack`, set `busy`, clear word index, go to SEND.
  - `dout_valid` rises the next cycle (capture latency 1).
- SEND:
  - `dout = digest[idx*BUS_WIDTH +: BUS_WIDTH]`.
  - Bytes outside the requested length are forced to 0.
  - `dout_last = (idx == nwords-1)`.
  - `dout_keep` is all ones, except on the last word when `rem != 0`; there it is `(1<<rem)-1`.
  - Transfer happens when `dout_valid & dout_ready`. On a non-last transfer, `idx` increments in the same cycle and the next word appears the following cycle, giving back-to-back throughput of one word per cycle.
  - On the last transfer: drop `dout_valid`, `dout_last` and `busy`; go to IDLE.
  - While `dout_valid & ~dout_ready`, `dout`, `dout_keep` and `dout_last` stay stable.

Boundary conditions:
- `rise` in SEND, or in the cycle of the last transfer: set `overrun`, drop the new digest, no `digest_ack`. `overrun` clears only on `reset`.
- `abort` in any state: next cycle goes to IDLE with `dout_valid`, `busy` and `idx` at 0. `abort` in the same cycle as `rise` takes priority, so no capture and no ack.
- `digest_bytes` greater than DIGEST_WIDTH/8 saturates to DIGEST_WIDTH/8.
- Single-word digest (len ≤ 8): first word has `dout_last=1`.

Test Plan:
- 64-byte digest, `digest = {64'h8,…,64'h1}`, `dout_ready=1`: `digest_ack` at cycle N. Eight words 1..8 on cycles N+1..N+8, keep=FF, `dout_last` on word 8. `busy` low at N+9.
- 20-byte digest: 3 words. Word 2 has keep=0x0F, upper 4 bytes zero, `dout_last=1`.
- Backpressure: 32-byte digest with `dout_ready` toggling 1,0,0,1,…: each word is held stable while stalled. Exactly 4 transfers, no word repeated or skipped.
- `digest_valid` held high for 30 cycles: exactly one `digest_ack`, one 8-word burst, `overrun=0`.
- Second `digest_valid` rise at word 3: `overrun=1` sticky. The first digest completes intact and the second produces no output.
- `reset`, then `abort`, asserted at word 4: outputs 0 next cycle. A following fresh rise captures and streams normally from word 0.
